// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
// Shared definitions for the dual-port RAM slice.
//   state_t          : clear-controller states (INIT = sequential clear,
//                      RUN = normal dual-port access)
//   RD_FIRST/WR_FIRST: values of the RD_MODE parameter
//   PRIO_P1/PRIO_P2  : values of the COLL_PRIO parameter
// -----------------------------------------------------------------------------
package dpram_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  localparam int PRIO_P1 = 1;
  localparam int PRIO_P2 = 2;

endpackage

// File: rtl/dpram_init_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_init_ctrl
// Clear sequencer for the RAM. After reset it walks every address from 0 to
// DEPTH-1, one per cycle, asking the storage to write zero, then parks in RUN.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | clearing address r_cnt this cycle; port requests ignored
//   RUN   | clear finished; ports own the memory
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset, restarts the clear
//   init_busy out  1 while rst is high or the clear is still running
//   init_addr out  address being cleared this cycle
//   init_we   out  zero-write strobe for init_addr
// -----------------------------------------------------------------------------
module dpram_init_ctrl
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_we
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_last;

  assign w_last = (r_cnt == {ADDR_W{1'b1}});

  // State register and clear counter. The counter wraps back to 0 on the
  // last clear, so it is already zero when RUN is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (w_last) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // Outputs. init_busy also covers the rst cycle itself so the ports are
  // locked out before the first reset edge has been taken.
  always_comb begin
    init_busy = 1'b1;
    init_we   = 1'b0;
    init_addr = r_cnt;
    case (r_state)
      INIT: begin
        init_busy = 1'b1;
        init_we   = ~rst;
      end
      RUN: begin
        init_busy = rst;
        init_we   = 1'b0;
      end
      default: begin
        init_busy = 1'b1;
        init_we   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dpram_param.sv
// -----------------------------------------------------------------------------
// dpram_param
// Parameterised true dual-port RAM, single clock, DEPTH = 2**ADDR_W words of
// DATA_W bits. Memory is cleared to zero after every reset by dpram_init_ctrl;
// port requests are ignored while the clear runs.
//
// Parameters
//   DATA_W    data width of both ports
//   ADDR_W    address width
//   RD_MODE   RD_FIRST: accesses return contents before this cycle's writes
//             WR_FIRST: accesses return contents after this cycle's writes
//   COLL_PRIO port (1 or 2) whose data is kept on a same-address dual write
//
// Ports
//   clk, rst             clock / synchronous active-high reset
//   en1, we1             port-1 request / write enable (we qualified by en)
//   addr1, data_in1      port-1 address / write data
//   data_out1, valid1    port-1 registered read data / one-cycle update pulse
//   en2 ... valid2       same for port 2
//   init_busy            clear in progress, requests ignored
//   collision            pulse: same-address dual write in previous cycle
// -----------------------------------------------------------------------------
module dpram_param
  import dpram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int RD_MODE   = 0,
  parameter int COLL_PRIO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data_in1,
  output logic [DATA_W-1:0] data_out1,
  output logic              valid1,
  input  logic              en2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data_in2,
  output logic [DATA_W-1:0] data_out2,
  output logic              valid2,
  output logic              init_busy,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_init_busy;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_init_we;

  logic              w_acc1;
  logic              w_acc2;
  logic              w_wr1;
  logic              w_wr2;
  logic              w_coll;
  logic              w_keep1;
  logic              w_keep2;
  logic [DATA_W-1:0] w_new1;
  logic [DATA_W-1:0] w_new2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  dpram_init_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .init_busy (w_init_busy),
    .init_addr (w_init_addr),
    .init_we   (w_init_we)
  );

  assign init_busy = w_init_busy;

  // Port qualification: nothing is accepted while the clear is running.
  assign w_acc1 = en1 & ~w_init_busy;
  assign w_acc2 = en2 & ~w_init_busy;
  assign w_wr1  = w_acc1 & we1;
  assign w_wr2  = w_acc2 & we2;
  assign w_coll = w_wr1 & w_wr2 & (addr1 == addr2);

  // On a collision only the priority port's write is committed.
  assign w_keep1 = w_wr1 & ~(w_coll & (COLL_PRIO == PRIO_P2));
  assign w_keep2 = w_wr2 & ~(w_coll & (COLL_PRIO != PRIO_P2));

  // Contents of each port's address as they will be after this cycle's
  // writes; this is what a write-first access returns, including the case
  // where the other port is the one writing that address.
  always_comb begin
    w_new1 = r_mem[addr1];
    if (w_keep1) begin
      w_new1 = data_in1;
    end else if (w_keep2 && (addr2 == addr1)) begin
      w_new1 = data_in2;
    end
  end

  always_comb begin
    w_new2 = r_mem[addr2];
    if (w_keep2) begin
      w_new2 = data_in2;
    end else if (w_keep1 && (addr1 == addr2)) begin
      w_new2 = data_in1;
    end
  end

  assign w_rd1 = (RD_MODE == RD_FIRST) ? r_mem[addr1] : w_new1;
  assign w_rd2 = (RD_MODE == RD_FIRST) ? r_mem[addr2] : w_new2;

  // Storage. No reset on the array itself: the clear sequence zeroes it.
  // The clear and port writes never coincide since ports are locked out
  // whenever init_we can be high.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[w_init_addr] <= '0;
    end else begin
      if (w_keep1) begin
        r_mem[addr1] <= data_in1;
      end
      if (w_keep2) begin
        r_mem[addr2] <= data_in2;
      end
    end
  end

  // Registered read ports and status pulses. A reset edge drops any access
  // requested in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out1 <= '0;
      data_out2 <= '0;
      valid1    <= 1'b0;
      valid2    <= 1'b0;
      collision <= 1'b0;
    end else begin
      valid1    <= w_acc1;
      valid2    <= w_acc2;
      collision <= w_coll;
      if (w_acc1) begin
        data_out1 <= w_rd1;
      end
      if (w_acc2) begin
        data_out2 <= w_rd2;
      end
    end
  end

endmodule

// File: tb/tb_dpram_param.sv
// Two instances share all inputs: dut A is read-first with port-1 priority,
// dut B is write-first with port-2 priority. A memory-snapshot model
// predicts both.
module tb_dpram_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en1 = 1'b0;
  logic          we1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] data_in1 = '0;
  logic          en2 = 1'b0;
  logic          we2 = 1'b0;
  logic [AW-1:0] addr2 = '0;
  logic [DW-1:0] data_in2 = '0;

  logic [DW-1:0] a_out1, a_out2, b_out1, b_out2;
  logic          a_v1, a_v2, a_busy, a_coll;
  logic          b_v1, b_v2, b_busy, b_coll;

  always #5 clk = ~clk;

  dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .COLL_PRIO(1)) dut_a (
    .clk(clk), .rst(rst),
    .en1(en1), .we1(we1), .addr1(addr1), .data_in1(data_in1),
    .data_out1(a_out1), .valid1(a_v1),
    .en2(en2), .we2(we2), .addr2(addr2), .data_in2(data_in2),
    .data_out2(a_out2), .valid2(a_v2),
    .init_busy(a_busy), .collision(a_coll)
  );

  dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .COLL_PRIO(2)) dut_b (
    .clk(clk), .rst(rst),
    .en1(en1), .we1(we1), .addr1(addr1), .data_in1(data_in1),
    .data_out1(b_out1), .valid1(b_v1),
    .en2(en2), .we2(we2), .addr2(addr2), .data_in2(data_in2),
    .data_out2(b_out2), .valid2(b_v2),
    .init_busy(b_busy), .collision(b_coll)
  );

  logic [19:0] obs_a, obs_b;
  assign obs_a = {a_out1, a_v1, a_out2, a_v2, a_coll, a_busy};
  assign obs_b = {b_out1, b_v1, b_out2, b_v2, b_coll, b_busy};

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 = dut A, index 1 = dut B.
  logic [DW-1:0] m_mem  [2][DEPTH];
  logic [DW-1:0] m_out1 [2];
  logic [DW-1:0] m_out2 [2];
  logic          m_v1   [2];
  logic          m_v2   [2];
  logic          m_coll [2];
  bit            m_last_rst = 1'b0;
  int            init_left  = 0;

  function automatic logic [19:0] exp_vec(input int i);
    return {m_out1[i], m_v1[i], m_out2[i], m_v2[i], m_coll[i],
            logic'(m_last_rst || (init_left > 0))};
  endfunction

  // Apply one cycle of inputs (called at a falling edge), advance the model
  // to what the outputs should be after the next rising edge, then move on
  // to the following falling edge.
  task automatic step(input bit r,
                      input bit e1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input bit e2, input bit w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    bit            busy_now;
    bit            wr1, wr2, coll;
    logic [DW-1:0] old_mem [DEPTH];
    rst = r;
    en1 = e1; we1 = w1; addr1 = a1; data_in1 = d1;
    en2 = e2; we2 = w2; addr2 = a2; data_in2 = d2;
    busy_now = r ? 1'b1 : (init_left > 0);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_out1[i] = '0; m_out2[i] = '0;
        m_v1[i] = 1'b0; m_v2[i] = 1'b0; m_coll[i] = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_mem[i][k] = '0;
      end else if (busy_now) begin
        m_v1[i] = 1'b0; m_v2[i] = 1'b0; m_coll[i] = 1'b0;
      end else begin
        for (int k = 0; k < DEPTH; k++) old_mem[k] = m_mem[i][k];
        wr1  = e1 && w1;
        wr2  = e2 && w2;
        coll = wr1 && wr2 && (a1 == a2);
        if (wr1) m_mem[i][a1] = d1;
        if (wr2) m_mem[i][a2] = d2;
        if (coll) m_mem[i][a1] = (i == 0) ? d1 : d2;
        m_coll[i] = coll;
        m_v1[i] = e1;
        m_v2[i] = e2;
        if (e1) m_out1[i] = (i == 0) ? old_mem[a1] : m_mem[i][a1];
        if (e2) m_out2[i] = (i == 0) ? old_mem[a2] : m_mem[i][a2];
      end
    end
    if (r) init_left = DEPTH;
    else if (busy_now) init_left = init_left - 1;
    m_last_rst = r;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    step(1, 1, 1, 4'd2, 8'h55, 1, 0, 4'd2, 8'h00);
    step(1, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (((i == 0) ? obs_a : obs_b) !== exp_vec(i)) begin
        failures++;
        $display("FAIL reset_state dut%0d got=%h exp=%h", i, (i == 0) ? obs_a : obs_b, exp_vec(i));
      end
    end
    checks++;
    if ({a_busy, a_v1, a_v2, a_coll, a_out1, a_out2} !== {4'b1000, 16'h0000}) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b v1=%b v2=%b coll=%b out1=%h out2=%h exp busy=1 rest 0",
               a_busy, a_v1, a_v2, a_coll, a_out1, a_out2);
    end
    // Random requests during the clear must be ignored; count busy cycles.
    n = 0;
    while (a_busy === 1'b1 && n < 40) begin
      step(0, $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), 8'($urandom),
              $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), 8'($urandom));
      n++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (((i == 0) ? obs_a : obs_b) !== exp_vec(i)) begin
          failures++;
          $display("FAIL init_ignore dut%0d cyc=%0d got=%h exp=%h", i, n, (i == 0) ? obs_a : obs_b, exp_vec(i));
        end
      end
    end
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL init_busy_len got=%0d exp=%0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      step(0, 1, 0, 4'(a), 8'($urandom), 1, 0, 4'(DEPTH - 1 - a), 8'($urandom));
      checks++;
      if ({a_out1, a_v1, a_out2, a_v2, b_out1, b_v1, b_out2, b_v2} !== {8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1}) begin
        failures++;
        $display("FAIL cleared_read addr=%0d got a=%h/%b %h/%b b=%h/%b %h/%b exp 00/1 all",
                 a, a_out1, a_v1, a_out2, a_v2, b_out1, b_v1, b_out2, b_v2);
      end
    end
  endtask

  task automatic test_write_read();
    step(0, 1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
    step(0, 0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00);
    checks++;
    if ({a_out2, a_v2, b_out2, b_v2} !== {8'hA5, 1'b1, 8'hA5, 1'b1}) begin
      failures++;
      $display("FAIL write_then_read got a=%h/%b b=%h/%b exp A5/1", a_out2, a_v2, b_out2, b_v2);
    end
    step(0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checks++;
    if ({a_out2, a_v2} !== {8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL hold_no_read got=%h/%b exp A5/0", a_out2, a_v2);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (((i == 0) ? obs_a : obs_b) !== exp_vec(i)) begin
        failures++;
        $display("FAIL write_read_model dut%0d got=%h exp=%h", i, (i == 0) ? obs_a : obs_b, exp_vec(i));
      end
    end
  endtask

  task automatic test_collision();
    step(0, 1, 1, 4'd7, 8'h3C, 1, 1, 4'd7, 8'hC3);
    checks++;
    if ({a_coll, b_coll, a_out1, b_out1} !== {1'b1, 1'b1, 8'h00, 8'hC3}) begin
      failures++;
      $display("FAIL collision_pulse got coll a=%b b=%b out1 a=%h b=%h exp 1 1 00 C3", a_coll, b_coll, a_out1, b_out1);
    end
    step(0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checks++;
    if ({a_coll, b_coll} !== 2'b00) begin
      failures++;
      $display("FAIL collision_once got a=%b b=%b exp 0 0", a_coll, b_coll);
    end
    step(0, 1, 0, 4'd7, 8'h00, 1, 1, 4'd8, 8'h99);
    checks++;
    if ({a_out1, b_out1, a_coll, b_coll} !== {8'h3C, 8'hC3, 2'b00}) begin
      failures++;
      $display("FAIL collision_winner got a=%h b=%h coll=%b%b exp 3C C3 00", a_out1, b_out1, a_coll, b_coll);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (((i == 0) ? obs_a : obs_b) !== exp_vec(i)) begin
        failures++;
        $display("FAIL collision_model dut%0d got=%h exp=%h", i, (i == 0) ? obs_a : obs_b, exp_vec(i));
      end
    end
  endtask

  task automatic test_cross_port();
    step(0, 1, 1, 4'd5, 8'h11, 0, 0, 4'd0, 8'h00);
    step(0, 1, 1, 4'd5, 8'h22, 1, 0, 4'd5, 8'h00);
    checks++;
    if ({a_out2, a_v2, b_out2, b_v2} !== {8'h11, 1'b1, 8'h22, 1'b1}) begin
      failures++;
      $display("FAIL cross_port got a=%h/%b b=%h/%b exp 11/1 22/1", a_out2, a_v2, b_out2, b_v2);
    end
    checks++;
    if ({a_out1, b_out1} !== {8'h11, 8'h22}) begin
      failures++;
      $display("FAIL own_write_data got a=%h b=%h exp 11 22", a_out1, b_out1);
    end
  endtask

  task automatic test_rst_in_run();
    step(0, 1, 1, 4'd9, 8'hFF, 0, 0, 4'd0, 8'h00);
    step(1, 1, 0, 4'd9, 8'h00, 1, 0, 4'd9, 8'h00);
    checks++;
    if ({a_v1, a_v2, b_v1, b_v2, a_busy, b_busy} !== 6'b000011) begin
      failures++;
      $display("FAIL rst_drop_read got v=%b%b%b%b busy=%b%b exp 0000 11", a_v1, a_v2, b_v1, b_v2, a_busy, b_busy);
    end
    for (int c = 0; c < DEPTH; c++) begin
      step(0, 1, c[0], 4'd9, 8'h77, 1, 0, 4'd9, 8'h00);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (((i == 0) ? obs_a : obs_b) !== exp_vec(i)) begin
          failures++;
          $display("FAIL rst_reinit dut%0d cyc=%0d got=%h exp=%h", i, c, (i == 0) ? obs_a : obs_b, exp_vec(i));
        end
      end
    end
    step(0, 1, 0, 4'd9, 8'h00, 0, 0, 4'd0, 8'h00);
    checks++;
    if ({a_out1, a_v1, b_out1, b_v1, a_busy} !== {8'h00, 1'b1, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_cleared_read got a=%h/%b b=%h/%b busy=%b exp 00/1 00/1 0", a_out1, a_v1, b_out1, b_v1, a_busy);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a1, a2;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        a1 = 4'($urandom_range(0, 3));
        a2 = 4'($urandom_range(0, 3));
      end else begin
        a1 = 4'($urandom);
        a2 = 4'($urandom);
      end
      step(($urandom_range(0, 149) == 0),
           $urandom_range(0, 1), $urandom_range(0, 1), a1, 8'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 1), a2, 8'($urandom));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (((i == 0) ? obs_a : obs_b) !== exp_vec(i)) begin
          failures++;
          $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", i, c, (i == 0) ? obs_a : obs_b, exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_collision();
    test_cross_port();
    test_rst_in_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
